reorder_buffer: RTL and testbench

//  Circular reorder buffer between the decoder/issue stage and the register file.

---
 rtl/reorder_buffer.sv | 190 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer between issue and the register file.
// Entries are allocated in program order at the tail, filled from the writeback
// bus, and retired in order from the head through a registered commit port.
// Issue logic can look up pending operands by tag, with a same-cycle wb bypass.
// Optional feature: define ROB_FLUSH_EN to add the flush port (drops all entries).
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [TAG_W-1:0]  qry1_tag,
  output logic              qry1_ready,
  output logic [DATA_W-1:0] qry1_data,
  input  logic [TAG_W-1:0]  qry2_tag,
  output logic              qry2_ready,
  output logic [DATA_W-1:0] qry2_data,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  output logic              commit_en,
  output logic [REG_W-1:0]  commit_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag
);

  localparam int CNT_W = IDX_W + 1;
  localparam int NUM_QRY = 2;
  // Tag value that never names a real entry (MSB set above the index field)
  localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Pointers and occupancy
  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  // Per-entry status bits and payload
  logic [DEPTH-1:0]  entry_busy;
  logic [DEPTH-1:0]  entry_ready;
  logic [DEPTH-1:0]  busy_next;
  logic [DEPTH-1:0]  ready_next;
  logic [REG_W-1:0]  entry_dest [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];

  // Per-cycle events
  logic              flush_now;
  logic              do_alloc;
  logic              do_commit;
  logic              wb_in_range;
  logic              wb_hit;
  logic [IDX_W-1:0]  wb_idx;

  // Query ports gathered into arrays so both share one generate body
  logic [TAG_W-1:0]  qry_tag   [NUM_QRY];
  logic              qry_ready [NUM_QRY];
  logic [DATA_W-1:0] qry_data  [NUM_QRY];

`ifdef ROB_FLUSH_EN
  assign flush_now = rdy && flush;
`else
  assign flush_now = 1'b0;
`endif

  // A full buffer refuses allocation even if the head retires this cycle,
  // because count only reflects the retire after the edge.
  assign alloc_ready = (count != FULL_COUNT);
  assign alloc_tag   = TAG_W'(tail);

  // Flush wins over every other update in the same cycle
  assign do_alloc    = rdy && alloc_valid && alloc_ready && !flush_now;
  assign do_commit   = rdy && entry_busy[head] && entry_ready[head] && !flush_now;

  // Tags with any bit set above the index field (including TAG_FREE) are ignored
  assign wb_idx      = wb_tag[IDX_W-1:0];
  assign wb_in_range = (wb_tag[TAG_W-1:IDX_W] == '0);
  assign wb_hit      = rdy && wb_valid && wb_in_range && entry_busy[wb_idx] && !flush_now;

  genvar gi;

  // Next-state of each entry's busy/ready bits
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic alloc_here;
    logic commit_here;
    logic wb_here;

    assign alloc_here  = do_alloc && (tail == IDX_W'(gi));
    assign commit_here = do_commit && (head == IDX_W'(gi));
    assign wb_here     = wb_hit && (wb_idx == IDX_W'(gi));

    // An allocating slot is never busy, so alloc and wb/commit cannot collide
    assign busy_next[gi]  = flush_now   ? 1'b0 :
                            alloc_here  ? 1'b1 :
                            commit_here ? 1'b0 :
                                          entry_busy[gi];
    assign ready_next[gi] = flush_now   ? 1'b0 :
                            alloc_here  ? 1'b0 :
                            wb_here     ? 1'b1 :
                                          entry_ready[gi];
  end

  assign qry_tag[0] = qry1_tag;
  assign qry_tag[1] = qry2_tag;
  assign qry1_ready = qry_ready[0];
  assign qry1_data  = qry_data[0];
  assign qry2_ready = qry_ready[1];
  assign qry2_data  = qry_data[1];

  // Operand lookup: stored result, or the writeback bus when it carries the tag
  for (gi = 0; gi < NUM_QRY; gi++) begin : g_qry
    logic [IDX_W-1:0] idx;
    logic             live;
    logic             bypass;

    assign idx    = qry_tag[gi][IDX_W-1:0];
    assign live   = (qry_tag[gi][TAG_W-1:IDX_W] == '0) && entry_busy[idx];
    assign bypass = wb_valid && (wb_tag == qry_tag[gi]);

    assign qry_ready[gi] = live && (entry_ready[idx] || bypass);
    assign qry_data[gi]  = !live           ? '0 :
                           bypass          ? wb_data :
                           entry_ready[idx] ? entry_data[idx] :
                                             '0;
  end

  // Entry payload: destination captured on allocate, result on writeback
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entry_dest[tail] <= alloc_dest;
    end
    if (wb_hit) begin
      entry_data[wb_idx] <= wb_data;
    end
  end

  // Control state and registered commit port; rdy=0 freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_busy  <= '0;
      entry_ready <= '0;
      commit_en   <= 1'b0;
      commit_reg  <= '0;
      commit_data <= '0;
      commit_tag  <= TAG_FREE;
    end else if (rdy) begin
      entry_busy  <= busy_next;
      entry_ready <= ready_next;
      if (flush_now) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        commit_en <= 1'b0;
      end else begin
        if (do_alloc) begin
          tail <= tail + IDX_W'(1);
        end
        if (do_commit) begin
          head <= head + IDX_W'(1);
        end
        if (do_alloc && !do_commit) begin
          count <= count + CNT_W'(1);
        end else if (!do_alloc && do_commit) begin
          count <= count - CNT_W'(1);
        end
        // Entries with dest x0 retire without a regfile write
        commit_en <= do_commit && (entry_dest[head] != '0);
        if (do_commit) begin
          commit_reg  <= entry_dest[head];
          commit_data <= entry_data[head];
          commit_tag  <= TAG_W'(head);
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus a randomized run,
// all checked against a queue-based model of the buffer kept in the bench.
module tb_reorder_buffer;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 4;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              rdy;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  qry1_tag;
  logic              qry1_ready;
  logic [DATA_W-1:0] qry1_data;
  logic [TAG_W-1:0]  qry2_tag;
  logic              qry2_ready;
  logic [DATA_W-1:0] qry2_data;
`ifdef ROB_FLUSH_EN
  logic              flush;
`endif
  logic              commit_en;
  logic [REG_W-1:0]  commit_reg;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;

  reorder_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .alloc_valid (alloc_valid),
    .alloc_dest  (alloc_dest),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .qry1_tag    (qry1_tag),
    .qry1_ready  (qry1_ready),
    .qry1_data   (qry1_data),
    .qry2_tag    (qry2_tag),
    .qry2_ready  (qry2_ready),
    .qry2_data   (qry2_data),
`ifdef ROB_FLUSH_EN
    .flush       (flush),
`endif
    .commit_en   (commit_en),
    .commit_reg  (commit_reg),
    .commit_data (commit_data),
    .commit_tag  (commit_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: program-ordered list of in-flight instructions
  typedef struct {
    int                idx;
    logic [REG_W-1:0]  dest;
    bit                done;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  int                m_tail;
  logic              m_en;
  logic [REG_W-1:0]  m_reg;
  logic [DATA_W-1:0] m_data;
  logic [TAG_W-1:0]  m_tag;
  int                checks;
  int                errors;

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    m_en   = 1'b0;
    m_reg  = '0;
    m_data = '0;
    m_tag  = 4'b1000;
  endtask

  // Apply one clock edge to the model using the currently driven inputs
  task automatic model_update();
    ent_t head_e;
    ent_t e;
    bit   retire;
    int   sz;
    if (!rdy) return;
`ifdef ROB_FLUSH_EN
    if (flush) begin
      q.delete();
      m_tail = 0;
      m_en   = 1'b0;
      return;
    end
`endif
    sz     = q.size();
    retire = (sz > 0) && q[0].done;
    if (retire) head_e = q[0];
    if (wb_valid && (wb_tag < DEPTH)) begin
      foreach (q[i]) begin
        if (q[i].idx == int'(wb_tag)) begin
          q[i].done = 1'b1;
          q[i].data = wb_data;
        end
      end
    end
    if (alloc_valid && (sz < DEPTH)) begin
      e.idx  = m_tail;
      e.dest = alloc_dest;
      e.done = 1'b0;
      e.data = '0;
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
    if (retire) begin
      m_en   = (head_e.dest != 0);
      m_reg  = head_e.dest;
      m_data = head_e.data;
      m_tag  = TAG_W'(head_e.idx);
      void'(q.pop_front());
    end else begin
      m_en = 1'b0;
    end
  endtask

  // Expected lookup result; chk_data=0 where the data value is unconstrained
  task automatic model_query(input logic [TAG_W-1:0] t, output logic r,
                             output logic [DATA_W-1:0] d, output bit chk_data);
    r = 1'b0;
    d = '0;
    chk_data = 1'b1;
    if (t < DEPTH) begin
      foreach (q[i]) begin
        if (q[i].idx == int'(t)) begin
          if (wb_valid && (wb_tag == t)) begin
            r = 1'b1;
            d = wb_data;
          end else if (q[i].done) begin
            r = 1'b1;
            d = q[i].data;
          end else begin
            chk_data = 1'b0;
          end
        end
      end
    end
  endtask

  // One clock: compare combinational outputs before the edge, registered after
  task automatic step(input string name);
    logic              er;
    logic [DATA_W-1:0] ed;
    bit                cd;
    logic              ar;
    logic [DATA_W-1:0] ad;
    logic [TAG_W-1:0]  qt;
    #1;
    checks++;
    if (alloc_ready !== (q.size() < DEPTH)) begin
      errors++;
      $display("FAIL %s alloc_ready: got %0b expected %0b", name, alloc_ready, q.size() < DEPTH);
    end
    checks++;
    if (alloc_tag !== TAG_W'(m_tail)) begin
      errors++;
      $display("FAIL %s alloc_tag: got %0d expected %0d", name, alloc_tag, m_tail);
    end
    for (int p = 0; p < 2; p++) begin
      qt = (p == 0) ? qry1_tag : qry2_tag;
      ar = (p == 0) ? qry1_ready : qry2_ready;
      ad = (p == 0) ? qry1_data : qry2_data;
      model_query(qt, er, ed, cd);
      checks++;
      if (ar !== er) begin
        errors++;
        $display("FAIL %s qry%0d_ready tag %0d: got %0b expected %0b", name, p + 1, qt, ar, er);
      end
      if (cd) begin
        checks++;
        if (ad !== ed) begin
          errors++;
          $display("FAIL %s qry%0d_data tag %0d: got %0h expected %0h", name, p + 1, qt, ad, ed);
        end
      end
    end
    @(posedge clk);
    model_update();
    #1;
    checks++;
    if (commit_en !== m_en) begin
      errors++;
      $display("FAIL %s commit_en: got %0b expected %0b", name, commit_en, m_en);
    end
    checks++;
    if (commit_reg !== m_reg) begin
      errors++;
      $display("FAIL %s commit_reg: got %0d expected %0d", name, commit_reg, m_reg);
    end
    checks++;
    if (commit_data !== m_data) begin
      errors++;
      $display("FAIL %s commit_data: got %0h expected %0h", name, commit_data, m_data);
    end
    checks++;
    if (commit_tag !== m_tag) begin
      errors++;
      $display("FAIL %s commit_tag: got %0d expected %0d", name, commit_tag, m_tag);
    end
    $display("[%0t] %s: alloc=%0b wb=%0b/%0d commit_en=%0b reg=%0d data=%0h tag=%0d",
             $time, name, alloc_valid, wb_valid, wb_tag, commit_en, commit_reg, commit_data, commit_tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    wb_valid    = 1'b0;
    wb_tag      = '0;
    wb_data     = '0;
    qry1_tag    = 4'd8;
    qry2_tag    = 4'd8;
`ifdef ROB_FLUSH_EN
    flush       = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy = 1'b1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic alloc_n(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = REG_W'(i + 1);
      step(name);
    end
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    alloc_n(3, "reset_fill");
    wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 32'h11;
    step("reset_wb");
    wb_valid = 1'b0;
    step("reset_commit");
    idle_inputs();
    qry1_tag = 4'd1;
    rst = 1'b1;
    #1;
    checks++;
    if (alloc_tag !== 4'd0) begin errors++; $display("FAIL reset alloc_tag: got %0d expected 0", alloc_tag); end
    checks++;
    if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset alloc_ready: got %0b expected 1", alloc_ready); end
    checks++;
    if (commit_en !== 1'b0) begin errors++; $display("FAIL reset commit_en: got %0b expected 0", commit_en); end
    checks++;
    if (commit_tag !== 4'b1000) begin errors++; $display("FAIL reset commit_tag: got %0d expected 8", commit_tag); end
    checks++;
    if (commit_reg !== 5'd0 || commit_data !== 32'd0) begin
      errors++; $display("FAIL reset commit_reg/data: got %0d/%0h expected 0/0", commit_reg, commit_data);
    end
    checks++;
    if (qry1_ready !== 1'b0) begin errors++; $display("FAIL reset qry1_ready: got %0b expected 0", qry1_ready); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    $display("[%0t] reset: mid-run reset applied", $time);
  endtask

  task automatic test_in_order();
    int got_reg[$];
    int got_data[$];
    int got_cyc[$];
    do_reset();
    alloc_n(5, "inorder_alloc");
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        wb_valid = 1'b1; wb_tag = TAG_W'(c); wb_data = DATA_W'(100 + c);
      end else begin
        wb_valid = 1'b0;
      end
      step("inorder_wb");
      if (commit_en === 1'b1) begin
        got_reg.push_back(int'(commit_reg));
        got_data.push_back(int'(commit_data));
        got_cyc.push_back(c);
      end
    end
    checks++;
    if (got_reg.size() != 5) begin
      errors++; $display("FAIL inorder commit count: got %0d expected 5", got_reg.size());
    end
    for (int i = 0; i < got_reg.size(); i++) begin
      checks++;
      if (got_reg[i] != i + 1 || got_data[i] != 100 + i || got_cyc[i] != got_cyc[0] + i) begin
        errors++;
        $display("FAIL inorder commit %0d: got x%0d=%0d at %0d expected x%0d=%0d at %0d",
                 i, got_reg[i], got_data[i], got_cyc[i], i + 1, 100 + i, got_cyc[0] + i);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    alloc_n(8, "full_alloc");
    checks++;
    if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full alloc_ready: got %0b expected 0", alloc_ready); end
    alloc_valid = 1'b1; alloc_dest = 5'd9;
    step("full_extra_alloc");
    alloc_valid = 1'b0;
    checks++;
    if (alloc_tag !== 4'd0 || alloc_ready !== 1'b0) begin
      errors++; $display("FAIL full ignored alloc: got tag %0d ready %0b expected tag 0 ready 0", alloc_tag, alloc_ready);
    end
    wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 32'h77;
    step("full_wb0");
    wb_valid = 1'b0;
    checks++;
    if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full before commit alloc_ready: got %0b expected 0", alloc_ready); end
    step("full_commit0");
    checks++;
    if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
      errors++; $display("FAIL full after commit: got ready %0b tag %0d expected ready 1 tag 0", alloc_ready, alloc_tag);
    end
    alloc_valid = 1'b1; alloc_dest = 5'd12;
    step("full_refill");
    alloc_valid = 1'b0;
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc_n(3, "ooo_alloc");
    wb_valid = 1'b1; wb_tag = 4'd2; wb_data = 32'h202;
    step("ooo_wb2");
    wb_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step("ooo_wait");
      checks++;
      if (commit_en !== 1'b0) begin errors++; $display("FAIL ooo early commit: got commit_en %0b expected 0", commit_en); end
    end
    wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 32'h200;
    step("ooo_wb0");
    wb_valid = 1'b0;
    step("ooo_commit0");
    checks++;
    if (commit_en !== 1'b1 || commit_tag !== 4'd0 || commit_data !== 32'h200) begin
      errors++; $display("FAIL ooo commit0: got en %0b tag %0d data %0h expected 1 0 200", commit_en, commit_tag, commit_data);
    end
    for (int i = 0; i < 2; i++) begin
      step("ooo_stall1");
      checks++;
      if (commit_en !== 1'b0) begin errors++; $display("FAIL ooo stall on tag1: got commit_en %0b expected 0", commit_en); end
    end
    wb_valid = 1'b1; wb_tag = 4'd1; wb_data = 32'h201;
    step("ooo_wb1");
    wb_valid = 1'b0;
    step("ooo_commit1");
    checks++;
    if (commit_en !== 1'b1 || commit_tag !== 4'd1) begin
      errors++; $display("FAIL ooo commit1: got en %0b tag %0d expected 1 1", commit_en, commit_tag);
    end
    step("ooo_commit2");
    checks++;
    if (commit_en !== 1'b1 || commit_tag !== 4'd2 || commit_data !== 32'h202) begin
      errors++; $display("FAIL ooo commit2: got en %0b tag %0d data %0h expected 1 2 202", commit_en, commit_tag, commit_data);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_n(4, "byp_alloc");
    qry1_tag = 4'd3; qry2_tag = 4'd2;
    wb_valid = 1'b1; wb_tag = 4'd3; wb_data = 32'hDEAD;
    #1;
    checks++;
    if (qry1_ready !== 1'b1 || qry1_data !== 32'hDEAD) begin
      errors++; $display("FAIL bypass qry1: got ready %0b data %0h expected 1 dead", qry1_ready, qry1_data);
    end
    checks++;
    if (qry2_ready !== 1'b0) begin errors++; $display("FAIL bypass qry2 pending: got %0b expected 0", qry2_ready); end
    step("byp_wb3");
    wb_valid = 1'b0;
    qry1_tag = 4'd8; qry2_tag = 4'd3;
    #1;
    checks++;
    if (qry2_ready !== 1'b1 || qry2_data !== 32'hDEAD) begin
      errors++; $display("FAIL bypass stored qry2: got ready %0b data %0h expected 1 dead", qry2_ready, qry2_data);
    end
    checks++;
    if (qry1_ready !== 1'b0 || qry1_data !== 32'd0) begin
      errors++; $display("FAIL bypass TAG_FREE: got ready %0b data %0h expected 0 0", qry1_ready, qry1_data);
    end
    step("byp_stored");
  endtask

  task automatic test_stall();
    do_reset();
    alloc_valid = 1'b1; alloc_dest = 5'd7;
    step("stall_alloc");
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 32'd55;
    step("stall_wb");
    wb_valid = 1'b0;
    step("stall_commit");
    rdy = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 5'd3;
    for (int i = 0; i < 3; i++) begin
      step("stall_hold");
      checks++;
      if (commit_en !== 1'b1 || commit_reg !== 5'd7 || commit_data !== 32'd55 || commit_tag !== 4'd0 || alloc_tag !== 4'd1) begin
        errors++;
        $display("FAIL stall hold: got en %0b reg %0d data %0d tag %0d atag %0d expected 1 7 55 0 1",
                 commit_en, commit_reg, commit_data, commit_tag, alloc_tag);
      end
    end
    rdy = 1'b1;
    alloc_valid = 1'b0;
    step("stall_release");
    checks++;
    if (commit_en !== 1'b0) begin errors++; $display("FAIL stall release commit_en: got %0b expected 0", commit_en); end
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    alloc_n(3, "flush_alloc");
    wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 32'h5;
    step("flush_wb");
    wb_valid = 1'b0;
    step("flush_commit");
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_dest = 5'd4;
    wb_valid = 1'b1; wb_tag = 4'd1; wb_data = 32'h6;
    step("flush_apply");
    idle_inputs();
    qry1_tag = 4'd1;
    #1;
    checks++;
    if (commit_en !== 1'b0 || alloc_tag !== 4'd0 || alloc_ready !== 1'b1 || qry1_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush: got en %0b atag %0d ready %0b q1 %0b expected 0 0 1 0",
               commit_en, alloc_tag, alloc_ready, qry1_ready);
    end
    step("flush_after");
  endtask
`endif

  task automatic test_random();
    int pend[$];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      alloc_valid = ($urandom_range(0, 2) != 0);
      alloc_dest  = REG_W'($urandom_range(0, 31));
      wb_valid    = ($urandom_range(0, 2) != 0);
      wb_data     = $urandom;
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(q[i].idx);
      if (pend.size() > 0 && $urandom_range(0, 3) != 0)
        wb_tag = TAG_W'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        wb_tag = TAG_W'($urandom_range(0, 15));
      qry1_tag = ($urandom_range(0, 3) == 0) ? wb_tag : TAG_W'($urandom_range(0, 8));
      qry2_tag = TAG_W'($urandom_range(0, 8));
`ifdef ROB_FLUSH_EN
      flush = ($urandom_range(0, 49) == 0);
`endif
      step("random");
    end
    idle_inputs();
    rdy = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_in_order();
    test_full();
    test_out_of_order();
    test_bypass();
    test_stall();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
